// File: rtl/cell_alloc_arbiter.sv
// Round-robin front end for the shared cell allocator: one allocation in flight,
// admission policy under memory pressure, and a one-cycle pass/fail response per request.
module cell_alloc_arbiter #(
  parameter int                      REQ_PORT_NUM  = 4,
  parameter int                      LEN_WIDTH     = 16,
  parameter int                      CELL_ID_WIDTH = 6,
  parameter int                      CELL_BYTES    = 1536,
  parameter logic [REQ_PORT_NUM-1:0] HIPRI_MASK    = REQ_PORT_NUM'(1),
  parameter int                      TIMEOUT       = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [REQ_PORT_NUM-1:0]         req_valid,
  input  logic [REQ_PORT_NUM*LEN_WIDTH-1:0] req_size,
  output logic [REQ_PORT_NUM-1:0]         req_ready,
  output logic [REQ_PORT_NUM-1:0]         resp_valid,
  output logic                            resp_success,
  output logic [CELL_ID_WIDTH-1:0]        resp_cell_id,
  output logic                            alloc_mem_req,
  output logic [LEN_WIDTH-1:0]            alloc_mem_size,
  input  logic [CELL_ID_WIDTH-1:0]        alloc_cell_id,
  input  logic                            alloc_mem_success,
  input  logic                            alloc_mem_intense,
  output logic [31:0]                     stat_alloc_ok,
  output logic [31:0]                     stat_alloc_fail
);

  localparam int PTR_W  = (REQ_PORT_NUM > 1) ? $clog2(REQ_PORT_NUM) : 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [LEN_WIDTH-1:0] MAX_SIZE  = LEN_WIDTH'(CELL_BYTES);
  localparam logic [PTR_W-1:0]     LAST_PORT = PTR_W'(REQ_PORT_NUM - 1);
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [PTR_W:0]       PORT_CNT  = (PTR_W+1)'(REQ_PORT_NUM);

  typedef enum logic [1:0] {IDLE, ALLOC, RESP} state_t;

  state_t                   state, state_nx;
  logic [PTR_W-1:0]         rr_ptr, gnt_idx, port_q, resp_port_nx, cand;
  logic [PTR_W:0]           cand_wide;
  logic                     gnt_found, gnt_accept, gnt_reject;
  logic [LEN_WIDTH-1:0]     gnt_size, size_q;
  logic [WAIT_W-1:0]        wait_cnt;
  logic [REQ_PORT_NUM-1:0]  resp_valid_q;
  logic                     enter_resp, resp_ok_nx;
  logic [CELL_ID_WIDTH-1:0] resp_id_nx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PORT) ? '0 : p + 1'b1;
  endfunction

  // Round-robin search starting at rr_ptr, wrapping modulo the port count
  always_comb begin : rr_search
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_wide = '0;
    cand      = '0;
    for (int k = 0; k < REQ_PORT_NUM; k++) begin
      cand_wide = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand_wide >= PORT_CNT) cand_wide = cand_wide - PORT_CNT;
      cand = cand_wide[PTR_W-1:0];
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    gnt_size = '0;
    for (int k = 0; k < REQ_PORT_NUM; k++) begin
      if (gnt_idx == PTR_W'(k)) gnt_size = req_size[k*LEN_WIDTH +: LEN_WIDTH];
    end
  end

  assign gnt_accept = (state == IDLE) && gnt_found;
  // Oversized/empty packets and low-priority ports under pressure never reach the allocator
  assign gnt_reject = (gnt_size == '0) || (gnt_size > MAX_SIZE) ||
                      (alloc_mem_intense && !HIPRI_MASK[gnt_idx]);

  always_comb begin : fsm_next
    state_nx     = state;
    enter_resp   = 1'b0;
    resp_ok_nx   = 1'b0;
    resp_id_nx   = '0;
    resp_port_nx = port_q;
    case (state)
      IDLE: begin
        if (gnt_found) begin
          resp_port_nx = gnt_idx;
          if (gnt_reject) begin
            state_nx   = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nx = ALLOC;
          end
        end
      end
      ALLOC: begin
        if (alloc_mem_success) begin
          state_nx   = RESP;
          enter_resp = 1'b1;
          resp_ok_nx = 1'b1;
          resp_id_nx = alloc_cell_id;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx   = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      port_q          <= '0;
      size_q          <= '0;
      wait_cnt        <= '0;
      resp_valid_q    <= '0;
      resp_success    <= 1'b0;
      resp_cell_id    <= '0;
      stat_alloc_ok   <= '0;
      stat_alloc_fail <= '0;
    end else begin
      state <= state_nx;
      if (gnt_accept) begin
        port_q   <= gnt_idx;
        size_q   <= gnt_size;
        rr_ptr   <= ptr_inc(gnt_idx);
        wait_cnt <= '0;
      end else if (state == ALLOC) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      resp_valid_q <= enter_resp ? (REQ_PORT_NUM'(1) << resp_port_nx) : '0;
      if (enter_resp) begin
        resp_success <= resp_ok_nx;
        resp_cell_id <= resp_id_nx;
        if (resp_ok_nx) stat_alloc_ok   <= stat_alloc_ok + 32'd1;
        else            stat_alloc_fail <= stat_alloc_fail + 32'd1;
      end
    end
  end

  // Request and response strobes are suppressed during a reset cycle so nothing leaks out
  assign req_ready      = gnt_accept ? (REQ_PORT_NUM'(1) << gnt_idx) : '0;
  assign alloc_mem_req  = (state == ALLOC) && !rst;
  assign alloc_mem_size = size_q;
  assign resp_valid     = resp_valid_q & {REQ_PORT_NUM{!rst}};

endmodule
